// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel-to-serial stage, MSB-first, with bit strobe and end-of-word pulse.
// Optional feature: define SER_PARITY_EN to append an even-parity bit to every word.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int            CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME - 1);
    localparam int            GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0]    GAP_LAST   = 4'(GAP_LAST_I);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-2:0] r_shift, w_shift_next;
    logic [CW-1:0]    r_bit_cnt, w_bit_cnt_next;
    logic [3:0]       r_gap_cnt, w_gap_cnt_next;
    logic             r_data_out, r_bit_valid, r_word_done, r_busy;
    logic             w_data_next, w_valid_next, w_done_next;
    logic             w_last_bit, w_xfer, w_next_bit;

    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    assign w_xfer     = load_valid && load_ready;

    // Ready depends only on state, so upstream never sees a path from load_valid.
    always_comb begin
        load_ready = 1'b0;
        case (r_state)
            IDLE:    load_ready = 1'b1;
            SHIFT:   load_ready = (GAP_CYCLES == 0) && w_last_bit;
            GAP:     load_ready = (r_gap_cnt == GAP_LAST);
            default: load_ready = 1'b0;
        endcase
    end

`ifdef SER_PARITY_EN
    logic r_parity;

    always_ff @(posedge Clk) begin
        if (reset)       r_parity <= 1'b0;
        else if (w_xfer) r_parity <= ^load_data;
    end

    always_comb begin
        w_next_bit = r_shift[WIDTH-2];
        if (r_bit_cnt == CW'(WIDTH - 1)) w_next_bit = r_parity;
    end
`else
    assign w_next_bit = r_shift[WIDTH-2];
`endif

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_data_next    = 1'b0;
        w_valid_next   = 1'b0;
        w_done_next    = 1'b0;
        case (r_state)
            IDLE: ;
            SHIFT: begin
                if (!w_last_bit) begin
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    w_shift_next   = r_shift << 1;
                    w_data_next    = w_next_bit;
                    w_valid_next   = 1'b1;
                    w_done_next    = (w_bit_cnt_next == LAST_BIT);
                end else if (GAP_CYCLES > 0) begin
                    w_state_next   = GAP;
                    w_gap_cnt_next = '0;
                end else begin
                    w_state_next = IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) w_state_next   = IDLE;
                else                       w_gap_cnt_next = r_gap_cnt + 4'd1;
            end
            default: w_state_next = IDLE;
        endcase
        // A transfer (from IDLE, last gap cycle or gap-free last bit) restarts the frame.
        if (w_xfer) begin
            w_state_next   = SHIFT;
            w_shift_next   = load_data[WIDTH-2:0];
            w_bit_cnt_next = '0;
            w_data_next    = load_data[WIDTH-1];
            w_valid_next   = 1'b1;
            w_done_next    = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_data_out  <= 1'b0;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_data_out  <= w_data_next;
            r_bit_valid <= w_valid_next;
            r_word_done <= w_done_next;
            r_busy      <= (w_state_next != IDLE);
        end
    end

    assign data_out  = r_data_out;
    assign bit_valid = r_bit_valid;
    assign word_done = r_word_done;
    assign busy      = r_busy;

endmodule
